// File: rtl/uart_pkg.sv
// Shared types and helpers for the UART receive path.
package uart_pkg;

  typedef enum logic [1:0] {
    PAR_NONE = 2'd0,
    PAR_EVEN = 2'd1,
    PAR_ODD  = 2'd2
  } parity_e;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } rx_state_e;

  // Centre tick of a bit period; majority samples sit at M-1, M, M+1.
  function automatic int unsigned mid_tick(input int unsigned oversample);
    return oversample / 2;
  endfunction

endpackage

// File: rtl/uart_rx_core_if.sv
// Consumer-side receive stream: head-of-FIFO frame with valid/ready.
interface uart_rx_core_if #(
  parameter int unsigned DATA_BITS = 8
) ();

  logic [DATA_BITS-1:0] rx_data;
  logic                 rx_perr;
  logic                 rx_ferr;
  logic                 rx_valid;
  logic                 rx_ready;

  modport master (
    output rx_data,
    output rx_perr,
    output rx_ferr,
    output rx_valid,
    input  rx_ready
  );

  modport slave (
    input  rx_data,
    input  rx_perr,
    input  rx_ferr,
    input  rx_valid,
    output rx_ready
  );

endinterface

// File: rtl/uart_rx_fifo.sv
// Synchronous frame FIFO with a registered head word; DEPTH must be a power of 2.
module uart_rx_fifo #(
  parameter int unsigned WIDTH = 10,
  parameter int unsigned DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] din,
  input  logic             pop,
  output logic [WIDTH-1:0] head_data,
  output logic             head_valid,
  output logic             full_c
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic [PW-1:0]    wr_q, wr_d, rd_q, rd_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] head_q, head_d;
  logic             valid_q, valid_d;
  logic             empty_c, pop_ok_c, push_ok_c;

  // A push into a full FIFO is only accepted when a pop frees a slot in the same cycle.
  always_comb begin
    mem_d     = mem_q;
    wr_d      = wr_q;
    full_c    = (cnt_q == CW'(DEPTH));
    empty_c   = (cnt_q == '0);
    pop_ok_c  = pop & ~empty_c;
    push_ok_c = push & (~full_c | pop_ok_c);
    rd_d      = pop_ok_c ? rd_q + PW'(1) : rd_q;
    if (push_ok_c) begin
      mem_d[wr_q] = din;
      wr_d        = wr_q + PW'(1);
    end
    cnt_d   = cnt_q + CW'(push_ok_c) - CW'(pop_ok_c);
    head_d  = (push_ok_c && (wr_q == rd_d)) ? din : mem_q[rd_d];
    valid_d = (cnt_d != '0);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < int'(DEPTH); i++) mem_q[i] <= '0;
      wr_q    <= '0;
      rd_q    <= '0;
      cnt_q   <= '0;
      head_q  <= '0;
      valid_q <= 1'b0;
    end else begin
      mem_q   <= mem_d;
      wr_q    <= wr_d;
      rd_q    <= rd_d;
      cnt_q   <= cnt_d;
      head_q  <= head_d;
      valid_q <= valid_d;
    end
  end

  assign head_data  = head_q;
  assign head_valid = valid_q;

endmodule

// File: rtl/uart_rx_core.sv
// Oversampled UART receiver: input synchroniser, 3-sample majority vote, frame FSM,
// frame FIFO and sticky overrun flag.
module uart_rx_core
  import uart_pkg::*;
#(
  parameter int unsigned DATA_BITS   = 8,
  parameter int unsigned OVERSAMPLE  = 16,
  parameter int unsigned PARITY_MODE = 0,
  parameter int unsigned STOP_BITS   = 1,
  parameter int unsigned FIFO_DEPTH  = 4,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          tick_en,
  input  logic          rx,
  input  logic          clr_err,
  output logic          overrun,
  output logic          busy,
  uart_rx_core_if.master rx_if
);

  localparam int unsigned TW = $clog2(OVERSAMPLE);
  localparam int unsigned BW = $clog2(DATA_BITS + 1);
  localparam int unsigned M  = mid_tick(OVERSAMPLE);
  localparam int unsigned FW = DATA_BITS + 2;
  localparam logic [1:0]  PAR_SEL = 2'(PARITY_MODE);

  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  rx_state_e              state_q, state_d;
  logic [TW-1:0]          tcnt_q, tcnt_d;
  logic [BW-1:0]          bcnt_q, bcnt_d;
  logic [DATA_BITS-1:0]   data_q, data_d;
  logic [1:0]             samp_q, samp_d;
  logic                   perr_q, perr_d;
  logic                   ferr_q, ferr_d;
  logic                   arm_q, arm_d;
  logic                   overrun_q, overrun_d;
  logic                   busy_q, busy_d;

  logic                   rx_s, maj_c, mid_c, last_c, push_c, pop_c, full_c, head_valid;
  logic [FW-1:0]          push_data_c, head_data;

  assign sync_d = {sync_q[SYNC_STAGES-2:0], rx};
  assign rx_s   = sync_q[SYNC_STAGES-1];

  // Frame FSM; counters and samples only move on tick_en.
  always_comb begin
    state_d     = state_q;
    tcnt_d      = tcnt_q;
    bcnt_d      = bcnt_q;
    data_d      = data_q;
    samp_d      = samp_q;
    perr_d      = perr_q;
    ferr_d      = ferr_q;
    arm_d       = arm_q | rx_s;
    push_c      = 1'b0;
    maj_c       = (samp_q[0] & samp_q[1]) | (samp_q[0] & rx_s) | (samp_q[1] & rx_s);
    mid_c       = (tcnt_q == TW'(M + 1));
    last_c      = (tcnt_q == TW'(OVERSAMPLE - 1));
    push_data_c = '0;
    if (tick_en) begin
      if (state_q == IDLE) begin
        if (!rx_s && arm_q) begin
          state_d = START;
          tcnt_d  = '0;
          bcnt_d  = '0;
          perr_d  = 1'b0;
          ferr_d  = 1'b0;
        end
      end else begin
        tcnt_d = last_c ? '0 : tcnt_q + TW'(1);
        if (tcnt_q == TW'(M - 1)) samp_d[0] = rx_s;
        if (tcnt_q == TW'(M))     samp_d[1] = rx_s;
        case (state_q)
          START: begin
            if (mid_c && maj_c) begin
              state_d = IDLE;
            end else if (last_c) begin
              state_d = DATA;
              bcnt_d  = '0;
            end
          end
          DATA: begin
            if (mid_c) begin
              for (int unsigned i = 0; i < DATA_BITS; i++) begin
                if (bcnt_q == BW'(i)) data_d[i] = maj_c;
              end
            end
            if (last_c) begin
              if (bcnt_q == BW'(DATA_BITS - 1)) begin
                bcnt_d  = '0;
                state_d = (PAR_SEL != PAR_NONE) ? PARITY : STOP;
              end else begin
                bcnt_d = bcnt_q + BW'(1);
              end
            end
          end
          PARITY: begin
            if (mid_c) perr_d = (PAR_SEL == PAR_ODD) ? (maj_c != ~^data_q) : (maj_c != ^data_q);
            if (last_c) state_d = STOP;
          end
          STOP: begin
            if (mid_c && !maj_c) ferr_d = 1'b1;
            // Leave half a bit early on the last stop bit to absorb baud mismatch.
            if (mid_c && (bcnt_q == BW'(STOP_BITS - 1))) begin
              push_c      = 1'b1;
              push_data_c = {perr_q, ferr_d, data_q};
              state_d     = IDLE;
              if ((data_q == '0) && ferr_d) arm_d = 1'b0;
            end else if (last_c) begin
              bcnt_d = bcnt_q + BW'(1);
            end
          end
          default: state_d = IDLE;
        endcase
      end
    end
    busy_d = (state_d != IDLE);
  end

  assign pop_c = head_valid & rx_if.rx_ready;

  // Sticky drop flag; clearing has priority over a same-cycle drop.
  always_comb begin
    overrun_d = clr_err ? 1'b0 : (overrun_q | (push_c & full_c & ~pop_c));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q    <= '1;
      state_q   <= IDLE;
      tcnt_q    <= '0;
      bcnt_q    <= '0;
      data_q    <= '0;
      samp_q    <= '0;
      perr_q    <= 1'b0;
      ferr_q    <= 1'b0;
      arm_q     <= 1'b0;
      overrun_q <= 1'b0;
      busy_q    <= 1'b0;
    end else begin
      sync_q    <= sync_d;
      state_q   <= state_d;
      tcnt_q    <= tcnt_d;
      bcnt_q    <= bcnt_d;
      data_q    <= data_d;
      samp_q    <= samp_d;
      perr_q    <= perr_d;
      ferr_q    <= ferr_d;
      arm_q     <= arm_d;
      overrun_q <= overrun_d;
      busy_q    <= busy_d;
    end
  end

  uart_rx_fifo #(
    .WIDTH (FW),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk        (clk),
    .rst_n      (rst_n),
    .push       (push_c),
    .din        (push_data_c),
    .pop        (pop_c),
    .head_data  (head_data),
    .head_valid (head_valid),
    .full_c     (full_c)
  );

  assign rx_if.rx_data  = head_data[DATA_BITS-1:0];
  assign rx_if.rx_ferr  = head_data[DATA_BITS];
  assign rx_if.rx_perr  = head_data[DATA_BITS+1];
  assign rx_if.rx_valid = head_valid;
  assign overrun        = overrun_q;
  assign busy           = busy_q;

endmodule
